// File: rtl/register_file.sv
// rtl/register_file.sv - 4x16 register file, two combinational read ports, one write port
// Same-cycle writes are forwarded to the read ports; reset clears storage and masks outputs.
module register_file #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] reg1,
   input  logic [ADDR_WIDTH-1:0] reg2,
   input  logic [ADDR_WIDTH-1:0] wreg,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  write_en,
   output logic [DATA_WIDTH-1:0] data1,
   output logic [DATA_WIDTH-1:0] data2
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] entry [DEPTH];
   logic                  fwd1;
   logic                  fwd2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            entry[i] <= '0;
         end
      end else if (write_en) begin
         entry[wreg] <= wdata;
      end
   end

   assign fwd1 = write_en && (reg1 == wreg);
   assign fwd2 = write_en && (reg2 == wreg);

   // Outputs are held at zero during reset so a pending write cannot leak through forwarding.
   always_comb begin
      data1 = entry[reg1];
      if (fwd1) begin
         data1 = wdata;
      end
      if (reset) begin
         data1 = '0;
      end
   end

   always_comb begin
      data2 = entry[reg2];
      if (fwd2) begin
         data2 = wdata;
      end
      if (reset) begin
         data2 = '0;
      end
   end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed scoreboard bench for register_file
module tb_register_file;

   logic        clk;
   logic        reset;
   logic [1:0]  reg1;
   logic [1:0]  reg2;
   logic [1:0]  wreg;
   logic [15:0] wdata;
   logic        write_en;
   logic [15:0] data1;
   logic [15:0] data2;

   logic [15:0] mdl [4];
   logic [15:0] exp_q [$];
   int          tests;
   int          fails;

   register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(2)) dut (
      .clk      (clk),
      .reset    (reset),
      .reg1     (reg1),
      .reg2     (reg2),
      .wreg     (wreg),
      .wdata    (wdata),
      .write_en (write_en),
      .data1    (data1),
      .data2    (data2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic compare(input string tag, input logic [15:0] obs);
      logic [15:0] e;
      e = exp_q.pop_front();
      tests++;
      assert (obs === e) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
   endtask

   // Expected values go on the queue before settling, then are popped against the DUT.
   task automatic check2(input string tag, input logic [15:0] e1, input logic [15:0] e2);
      exp_q.push_back(e1);
      exp_q.push_back(e2);
      #1;
      compare({tag, "/data1"}, data1);
      compare({tag, "/data2"}, data2);
   endtask

   task automatic do_write(input logic [1:0] a, input logic [15:0] d);
      @(negedge clk);
      write_en = 1'b1;
      wreg     = a;
      wdata    = d;
      @(posedge clk);
      mdl[a] = d;
      @(negedge clk);
      write_en = 1'b0;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b1;
      reg1 = 2'd0; reg2 = 2'd0; wreg = 2'd0; wdata = 16'h0; write_en = 1'b0;
      for (int i = 0; i < 4; i++) mdl[i] = 16'h0;
      #6;
      check2("reset_state", 16'h0000, 16'h0000);
      @(negedge clk);
      reset = 1'b0;

      // Fill with 0x1234, then assert reset mid-cycle and expect zeros with no edge.
      for (int i = 0; i < 4; i++) do_write(2'(i), 16'h1234);
      reg1 = 2'd0; reg2 = 2'd3;
      check2("pre_reset", mdl[0], mdl[3]);
      #2;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) mdl[i] = 16'h0;
      check2("async_reset", 16'h0000, 16'h0000);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         reg1 = 2'(i); reg2 = 2'(3 - i);
         check2("post_reset_sweep", mdl[i], mdl[3 - i]);
      end

      do_write(2'd1, 16'd15);
      reg1 = 2'd0; reg2 = 2'd1;
      check2("write_read", 16'd0, 16'd15);

      write_en = 1'b0; wreg = 2'd1; wdata = 16'd10;
      @(posedge clk);
      @(negedge clk);
      check2("write_disable", 16'd0, 16'd15);

      write_en = 1'b1; wreg = 2'd1; wdata = 16'd20; reg1 = 2'd0; reg2 = 2'd1;
      check2("fwd_before_edge", 16'd0, 16'd20);
      @(posedge clk);
      mdl[1] = 16'd20;
      check2("fwd_after_edge", 16'd0, 16'd20);
      @(negedge clk);
      write_en = 1'b0;
      check2("stored_after_fwd", 16'd0, 16'd20);

      do_write(2'd3, 16'hBEEF);
      reg1 = 2'd3; reg2 = 2'd3;
      check2("dual_same", 16'hBEEF, 16'hBEEF);

      for (int i = 0; i < 4; i++) do_write(2'(i), 16'h00A0 + 16'(i));
      for (int a = 0; a < 4; a++) begin
         for (int b = 0; b < 4; b++) begin
            reg1 = 2'(a); reg2 = 2'(b);
            check2("sweep", 16'h00A0 + 16'(a), 16'h00A0 + 16'(b));
         end
      end

      do_write(2'd0, 16'h1111);
      do_write(2'd0, 16'h2222);
      reg1 = 2'd0; reg2 = 2'd1;
      check2("back_to_back", 16'h2222, mdl[1]);

      // Reset collides with a write edge; forwarding must also be masked.
      @(negedge clk);
      write_en = 1'b1; wreg = 2'd2; wdata = 16'hFFFF; reg1 = 2'd2; reg2 = 2'd2;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) mdl[i] = 16'h0;
      check2("reset_masks_fwd", 16'h0000, 16'h0000);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0; write_en = 1'b0;
      check2("reset_vs_write", 16'h0000, mdl[2]);

      do_write(2'd2, 16'h5A5A);
      reg1 = 2'd2; reg2 = 2'd0;
      check2("first_write_after_reset", 16'h5A5A, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
